pc_sequencer: RTL

Sequential front end for the PC update path. Sits between the opcode-driven PC control decoder and the PC register/target mux. Its outputs select among M[0], M[1], X[SP] and R[rb], enable the PC, and choose between increment-by-1/2 and loading the target. It sequences boot (PC ← M[0]), pipeline stalls, branch flushes and interrupt entry (drain, push PC, PC ← M[1]); otherwise it passes decoder requests straight through.

---
 rtl/pc_sequencer_if.sv | 57 +++++
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_seq_if -- signal bundle between the PC control decoder / hazard unit /
// interrupt source and the PC sequencer, plus the sequencer's outputs toward
// the PC register, target mux, fetch stage and stack unit.
//
// Modports:
//   master : the environment side (drives decoder requests, stall, intr;
//            observes the PC controls).
//   slave  : the sequencer side (pc_sequencer).
//
// Signals:
//   dec_s_target[1:0] decoder target select (0 M[0], 1 M[1], 2 X[SP], 3 R[rb])
//   dec_e_pc          decoder PC enable
//   dec_e_imm         decoder increment size (0 -> +1, 1 -> +2)
//   dec_load          decoder mode (0 -> load target, 1 -> increment)
//   dec_is_rti        instruction in decode is RTI
//   stall             hazard unit freezes PC
//   intr              level interrupt request, synchronous to clk
//   pc_s_target[1:0]  PC target mux select
//   pc_e              PC register enable
//   pc_e_imm          increment size
//   pc_load           0 -> load target, 1 -> increment
//   flush_if          discard the instruction being fetched
//   push_pc           stack unit pushes current PC
//   int_ack           one-cycle interrupt entry acknowledge
//   seq_state[2:0]    sequencer state, for debug
// -----------------------------------------------------------------------------
interface pc_seq_if;
  logic [1:0] dec_s_target;
  logic       dec_e_pc;
  logic       dec_e_imm;
  logic       dec_load;
  logic       dec_is_rti;
  logic       stall;
  logic       intr;

  logic [1:0] pc_s_target;
  logic       pc_e;
  logic       pc_e_imm;
  logic       pc_load;
  logic       flush_if;
  logic       push_pc;
  logic       int_ack;
  logic [2:0] seq_state;

  modport master (
    output dec_s_target, dec_e_pc, dec_e_imm, dec_load, dec_is_rti, stall, intr,
    input  pc_s_target, pc_e, pc_e_imm, pc_load, flush_if, push_pc, int_ack,
           seq_state
  );

  modport slave (
    input  dec_s_target, dec_e_pc, dec_e_imm, dec_load, dec_is_rti, stall, intr,
    output pc_s_target, pc_e, pc_e_imm, pc_load, flush_if, push_pc, int_ack,
           seq_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer -- sequential front end of the PC update path.
//
// Sequences boot (PC <- M[0]), pipeline stalls, branch flushes and interrupt
// entry (drain the pipe, push PC, PC <- M[1]). In RUN the decoder's PC request
// passes straight through combinationally (zero-cycle latency).
//
// Parameters:
//   DRAIN_CYCLES  bubble cycles before the PC is saved on interrupt entry
//                 (legal range 1..7, must fit the 3-bit drain counter).
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pc_seq_if.slave (decoder requests in, PC controls out)
//
// Optional feature:
//   PC_SEQ_INT_MASK_EN  when defined, interrupts are masked while a handler
//                       runs (from VECTOR until an RTI decode cycle with
//                       stall=0). When undefined, handlers may be nested.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic       clk,
  input logic       rst_n,
  pc_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOOT   = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_SAVE   = 3'd4,
    S_VECTOR = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] drain_cnt;
  logic       intr_pend;
  logic       masked;
  logic       accept;

`ifdef PC_SEQ_INT_MASK_EN
  logic in_handler;
  assign masked = in_handler;
`else
  assign masked = 1'b0;
`endif

  // Entry is only taken on a plain sequential cycle so that a redirect or an
  // RTI is never lost; a blocked request simply retries next cycle.
  assign accept = (state == S_RUN) & ~bus.stall & intr_pend & bus.dec_load &
                  ~bus.dec_is_rti & ~masked;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      drain_cnt  <= '0;
      intr_pend  <= 1'b0;
`ifdef PC_SEQ_INT_MASK_EN
      in_handler <= 1'b0;
`endif
    end else begin
      // A request present on the VECTOR edge re-arms the pending flag:
      // setting takes priority over the clear.
      intr_pend <= bus.intr | (intr_pend & (state != S_VECTOR));

      unique case (state)
        S_IDLE: state <= S_BOOT;
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (accept) begin
            state     <= S_DRAIN;
            drain_cnt <= 3'(DRAIN_CYCLES - 1);
          end
`ifdef PC_SEQ_INT_MASK_EN
          if (!bus.stall && bus.dec_is_rti) in_handler <= 1'b0;
`endif
        end
        S_DRAIN: begin
          // Stalled cycles do not count toward the drain.
          if (!bus.stall) begin
            if (drain_cnt == '0) state <= S_SAVE;
            else drain_cnt <= drain_cnt - 3'd1;
          end
        end
        S_SAVE: state <= S_VECTOR;
        S_VECTOR: begin
          state <= S_RUN;
`ifdef PC_SEQ_INT_MASK_EN
          in_handler <= 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the current state (and, in RUN, the live decoder inputs),
  // so an asynchronous reset forces them all low immediately.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    bus.pc_s_target = 2'b00;
    bus.pc_e        = 1'b0;
    bus.pc_e_imm    = 1'b0;
    bus.pc_load     = 1'b0;
    bus.flush_if    = 1'b0;
    bus.push_pc     = 1'b0;
    bus.int_ack     = 1'b0;

    unique case (state)
      S_BOOT: begin
        bus.pc_e     = 1'b1;
        bus.flush_if = 1'b1;
      end
      S_RUN: begin
        bus.pc_s_target = bus.dec_s_target;
        bus.pc_e_imm    = bus.dec_e_imm;
        bus.pc_load     = bus.dec_load;
        if (!bus.stall) begin
          bus.pc_e     = bus.dec_e_pc;
          // A taken redirect makes the in-flight fetch stale.
          bus.flush_if = bus.dec_e_pc & ~bus.dec_load;
        end
      end
      S_DRAIN: bus.flush_if = 1'b1;
      S_SAVE: begin
        bus.push_pc  = 1'b1;
        bus.flush_if = 1'b1;
      end
      S_VECTOR: begin
        bus.pc_e        = 1'b1;
        bus.pc_s_target = 2'b01;
        bus.flush_if    = 1'b1;
        bus.int_ack     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.seq_state = state;

endmodule
